// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//
// BCD m:ss.t countdown timer. A preset is loaded with ld, counting starts with
// go, and each en tick in RUN takes one tenth of a second off the count. When
// the count reaches 0:00.0 a one-cycle done pulse is produced and the timer
// either stops in DONE or, with AUTO_RELOAD=1, reloads the preset and keeps
// running. The digit layout matches the up-counting timing counter so the
// same display path can be driven from q0/qs/qm.
//
// Parameters:
//   AUTO_RELOAD  0: stop in DONE on expiry; 1: reload preset and keep running
//
// Ports:
//   clk   in   system clock, all state changes on rising edge
//   r     in   synchronous reset, active-high, overrides everything
//   en    in   one-tenth-second time-base tick, acted on only in RUN
//   ld    in   load preset from t_in/s_in/m_in (clamped to legal BCD)
//   t_in  in   [3:0] preset tenths
//   s_in  in   [7:0] preset seconds BCD ([7:4] tens, [3:0] units)
//   m_in  in   [3:0] preset minutes
//   go    in   start / resume counting
//   stop  in   pause counting
//   q0    out  [3:0] current tenths
//   qs    out  [7:0] current seconds BCD
//   qm    out  [3:0] current minutes
//   busy  out  high while in RUN
//   done  out  one-cycle pulse on expiry
// -----------------------------------------------------------------------------
module countdown_timer #(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic       clk,
    input  logic       r,
    input  logic       en,
    input  logic       ld,
    input  logic [3:0] t_in,
    input  logic [7:0] s_in,
    input  logic [3:0] m_in,
    input  logic       go,
    input  logic       stop,
    output logic [3:0] q0,
    output logic [7:0] qs,
    output logic [3:0] qm,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Count and preset are kept packed as {minutes, seconds_tens,
    // seconds_units, tenths}, one nibble each.
    localparam logic [15:0] ZERO_COUNT = 16'h0000;

    // Force every digit of a raw preset into its legal BCD range.
    function automatic logic [15:0] clamp_preset(
        input logic [3:0] t,
        input logic [7:0] s,
        input logic [3:0] m
    );
        logic [3:0] v_t;
        logic [3:0] v_su;
        logic [3:0] v_st;
        logic [3:0] v_m;
        v_t  = (t      > 4'd9) ? 4'd9 : t;
        v_su = (s[3:0] > 4'd9) ? 4'd9 : s[3:0];
        v_st = (s[7:4] > 4'd5) ? 4'd5 : s[7:4];
        v_m  = (m      > 4'd9) ? 4'd9 : m;
        return {v_m, v_st, v_su, v_t};
    endfunction

    // Subtract one tenth from a packed m:ss.t value with BCD borrows.
    // Minutes never wrap below zero; a zero count is not decremented in RUN.
    function automatic logic [15:0] dec_count(input logic [15:0] c);
        logic [3:0] v_t;
        logic [3:0] v_su;
        logic [3:0] v_st;
        logic [3:0] v_m;
        v_t  = c[3:0];
        v_su = c[7:4];
        v_st = c[11:8];
        v_m  = c[15:12];
        if (v_t != 4'd0) begin
            v_t = v_t - 4'd1;
        end else begin
            v_t = 4'd9;
            if (v_su != 4'd0) begin
                v_su = v_su - 4'd1;
            end else begin
                v_su = 4'd9;
                if (v_st != 4'd0) begin
                    v_st = v_st - 4'd1;
                end else begin
                    v_st = 4'd5;
                    if (v_m != 4'd0) begin
                        v_m = v_m - 4'd1;
                    end else begin
                        v_m = 4'd0;
                    end
                end
            end
        end
        return {v_m, v_st, v_su, v_t};
    endfunction

    state_t      r_state;
    logic [15:0] r_count;
    logic [15:0] r_preset;
    logic        r_busy;
    logic        r_done;

    state_t      w_state_nxt;
    logic [15:0] w_count_nxt;
    logic [15:0] w_preset_nxt;
    logic        w_done_nxt;
    logic [15:0] w_count_dec;
    logic        w_count_zero;

    assign w_count_dec  = dec_count(r_count);
    assign w_count_zero = (r_count == ZERO_COUNT);

    // State, count, preset and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (r) begin
            r_state  <= ST_IDLE;
            r_count  <= ZERO_COUNT;
            r_preset <= ZERO_COUNT;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_preset <= w_preset_nxt;
            r_busy   <= (w_state_nxt == ST_RUN);
            r_done   <= w_done_nxt;
        end
    end

    // Next-state logic; input priority is ld > stop > go > en.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_preset_nxt = r_preset;
        w_done_nxt   = 1'b0;

        if (ld) begin
            w_count_nxt  = clamp_preset(t_in, s_in, m_in);
            w_preset_nxt = clamp_preset(t_in, s_in, m_in);
            w_state_nxt  = ST_IDLE;
        end else if (stop) begin
            // Outside RUN stop does nothing, but it still masks go and en.
            if (r_state == ST_RUN) begin
                w_state_nxt = ST_PAUSE;
            end else begin
                w_state_nxt = r_state;
            end
        end else if (go) begin
            case (r_state)
                ST_IDLE, ST_PAUSE: begin
                    if (w_count_zero) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end else if (en && (r_state == ST_RUN)) begin
            if (w_count_dec == ZERO_COUNT) begin
                w_done_nxt = 1'b1;
                if (AUTO_RELOAD) begin
                    w_count_nxt = r_preset;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_count_nxt = ZERO_COUNT;
                    w_state_nxt = ST_DONE;
                end
            end else begin
                w_count_nxt = w_count_dec;
            end
        end else begin
            w_state_nxt = r_state;
        end
    end

    assign q0   = r_count[3:0];
    assign qs   = r_count[11:4];
    assign qm   = r_count[15:12];
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

    logic       clk;
    logic       r;
    logic       en;
    logic       ld;
    logic [3:0] t_in;
    logic [7:0] s_in;
    logic [3:0] m_in;
    logic       go;
    logic       stop;

    logic [3:0] q0_a;
    logic [7:0] qs_a;
    logic [3:0] qm_a;
    logic       busy_a;
    logic       done_a;

    logic [3:0] q0_b;
    logic [7:0] qs_b;
    logic [3:0] qm_b;
    logic       busy_b;
    logic       done_b;

    int checks;
    int errors;

    countdown_timer #(.AUTO_RELOAD(1'b0)) dut_a (
        .clk(clk), .r(r), .en(en), .ld(ld), .t_in(t_in), .s_in(s_in),
        .m_in(m_in), .go(go), .stop(stop),
        .q0(q0_a), .qs(qs_a), .qm(qm_a), .busy(busy_a), .done(done_a)
    );

    countdown_timer #(.AUTO_RELOAD(1'b1)) dut_b (
        .clk(clk), .r(r), .en(en), .ld(ld), .t_in(t_in), .s_in(s_in),
        .m_in(m_in), .go(go), .stop(stop),
        .q0(q0_b), .qs(qs_b), .qm(qm_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] t, input logic [7:0] s, input logic [3:0] m);
        ld = 1'b1; t_in = t; s_in = s; m_in = m;
        cycle();
        ld = 1'b0;
    endtask

    task automatic do_go();
        go = 1'b1;
        cycle();
        go = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    task automatic do_en(input int n);
        for (int i = 0; i < n; i++) begin
            en = 1'b1;
            cycle();
            en = 1'b0;
        end
    endtask

    task automatic test_reset();
        r = 1'b1;
        cycle();
        cycle();
        r = 1'b0;
        checks++;
        if ({qm_a, qs_a, q0_a, busy_a, done_a} !== 18'h0) begin
            errors++;
            $display("FAIL reset_a: got %h/%h/%h busy=%b done=%b, want 0/00/0 0 0", qm_a, qs_a, q0_a, busy_a, done_a);
        end
        checks++;
        if ({qm_b, qs_b, q0_b, busy_b, done_b} !== 18'h0) begin
            errors++;
            $display("FAIL reset_b: got %h/%h/%h busy=%b done=%b, want 0/00/0 0 0", qm_b, qs_b, q0_b, busy_b, done_b);
        end
    endtask

    task automatic test_reset_mid_run();
        do_load(4'h5, 8'h30, 4'h1);
        do_go();
        do_en(5);
        checks++;
        if ({qm_a, qs_a, q0_a} !== 16'h1300 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_count: got %h%h%h busy=%b, want 1300 busy=1", qm_a, qs_a, q0_a, busy_a);
        end
        r = 1'b1;
        cycle();
        r = 1'b0;
        checks++;
        if ({qm_a, qs_a, q0_a} !== 16'h0000 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: got %h%h%h busy=%b done=%b, want 0000 0 0", qm_a, qs_a, q0_a, busy_a, done_a);
        end
        do_en(1);
        checks++;
        if ({qm_a, qs_a, q0_a} !== 16'h0000 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL en_after_reset: got %h%h%h busy=%b, want 0000 busy=0", qm_a, qs_a, q0_a, busy_a);
        end
    endtask

    task automatic test_borrow_chain();
        do_load(4'h0, 8'h00, 4'h1);
        do_go();
        do_en(1);
        checks++;
        if ({qm_a, qs_a, q0_a} !== 16'h0599 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL borrow_first: got %h%h%h busy=%b, want 0599 busy=1", qm_a, qs_a, q0_a, busy_a);
        end
        do_en(598);
        checks++;
        if ({qm_a, qs_a, q0_a} !== 16'h0001 || busy_a !== 1'b1 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL borrow_last_tick: got %h%h%h busy=%b done=%b, want 0001 1 0", qm_a, qs_a, q0_a, busy_a, done_a);
        end
        do_en(1);
        checks++;
        if ({qm_a, qs_a, q0_a} !== 16'h0000 || busy_a !== 1'b0 || done_a !== 1'b1) begin
            errors++;
            $display("FAIL borrow_expiry: got %h%h%h busy=%b done=%b, want 0000 0 1", qm_a, qs_a, q0_a, busy_a, done_a);
        end
        do_en(1);
        checks++;
        if ({qm_a, qs_a, q0_a} !== 16'h0000 || done_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL done_one_cycle: got %h%h%h busy=%b done=%b, want 0000 0 0", qm_a, qs_a, q0_a, busy_a, done_a);
        end
    endtask

    task automatic test_pause_resume();
        do_load(4'h0, 8'h02, 4'h0);
        do_go();
        do_en(3);
        checks++;
        if ({qm_a, qs_a, q0_a} !== 16'h0017) begin
            errors++;
            $display("FAIL pause_pre: got %h%h%h, want 0017", qm_a, qs_a, q0_a);
        end
        do_stop();
        do_en(4);
        checks++;
        if ({qm_a, qs_a, q0_a} !== 16'h0017 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL pause_hold: got %h%h%h busy=%b, want 0017 busy=0", qm_a, qs_a, q0_a, busy_a);
        end
        do_go();
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL resume_busy: got %b, want 1", busy_a);
        end
        do_en(16);
        checks++;
        if ({qm_a, qs_a, q0_a} !== 16'h0001 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL resume_count: got %h%h%h done=%b, want 0001 done=0", qm_a, qs_a, q0_a, done_a);
        end
        do_en(1);
        checks++;
        if ({qm_a, qs_a, q0_a} !== 16'h0000 || done_a !== 1'b1 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL resume_expiry: got %h%h%h busy=%b done=%b, want 0000 0 1", qm_a, qs_a, q0_a, busy_a, done_a);
        end
        // go in DONE must be ignored
        do_go();
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || {qm_a, qs_a, q0_a} !== 16'h0000) begin
            errors++;
            $display("FAIL go_in_done: got %h%h%h busy=%b done=%b, want 0000 0 0", qm_a, qs_a, q0_a, busy_a, done_a);
        end
    endtask

    task automatic test_priority();
        do_load(4'h0, 8'h05, 4'h0);
        do_go();
        ld = 1'b1; en = 1'b1; t_in = 4'h0; s_in = 8'h03; m_in = 4'h0;
        cycle();
        ld = 1'b0; en = 1'b0;
        checks++;
        if ({qm_a, qs_a, q0_a} !== 16'h0030 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL ld_over_en: got %h%h%h busy=%b, want 0030 busy=0", qm_a, qs_a, q0_a, busy_a);
        end
        do_go();
        do_en(2);
        stop = 1'b1; go = 1'b1;
        cycle();
        stop = 1'b0; go = 1'b0;
        checks++;
        if ({qm_a, qs_a, q0_a} !== 16'h0028 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL stop_over_go: got %h%h%h busy=%b, want 0028 busy=0", qm_a, qs_a, q0_a, busy_a);
        end
        do_en(1);
        checks++;
        if ({qm_a, qs_a, q0_a} !== 16'h0028) begin
            errors++;
            $display("FAIL en_in_pause: got %h%h%h, want 0028", qm_a, qs_a, q0_a);
        end
    endtask

    task automatic test_clamp_zero();
        do_load(4'hF, 8'h7A, 4'hC);
        checks++;
        if ({qm_a, qs_a, q0_a} !== 16'h9599) begin
            errors++;
            $display("FAIL clamp: got %h%h%h, want 9599", qm_a, qs_a, q0_a);
        end
        do_load(4'h0, 8'h00, 4'h0);
        do_go();
        checks++;
        if (done_a !== 1'b1 || busy_a !== 1'b0 || {qm_a, qs_a, q0_a} !== 16'h0000) begin
            errors++;
            $display("FAIL zero_go: got %h%h%h busy=%b done=%b, want 0000 0 1", qm_a, qs_a, q0_a, busy_a, done_a);
        end
        cycle();
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL zero_go_after: got busy=%b done=%b, want 0 0", busy_a, done_a);
        end
    endtask

    task automatic test_auto_reload();
        do_load(4'h3, 8'h00, 4'h0);
        do_go();
        do_en(2);
        checks++;
        if ({qm_b, qs_b, q0_b} !== 16'h0001 || busy_b !== 1'b1 || done_b !== 1'b0) begin
            errors++;
            $display("FAIL reload_pre: got %h%h%h busy=%b done=%b, want 0001 1 0", qm_b, qs_b, q0_b, busy_b, done_b);
        end
        do_en(1);
        checks++;
        if ({qm_b, qs_b, q0_b} !== 16'h0003 || busy_b !== 1'b1 || done_b !== 1'b1) begin
            errors++;
            $display("FAIL reload_first: got %h%h%h busy=%b done=%b, want 0003 1 1", qm_b, qs_b, q0_b, busy_b, done_b);
        end
        checks++;
        if ({qm_a, qs_a, q0_a} !== 16'h0000 || busy_a !== 1'b0 || done_a !== 1'b1) begin
            errors++;
            $display("FAIL noreload_expiry: got %h%h%h busy=%b done=%b, want 0000 0 1", qm_a, qs_a, q0_a, busy_a, done_a);
        end
        do_en(1);
        checks++;
        if ({qm_b, qs_b, q0_b} !== 16'h0002 || done_b !== 1'b0 || busy_b !== 1'b1) begin
            errors++;
            $display("FAIL reload_continue: got %h%h%h busy=%b done=%b, want 0002 1 0", qm_b, qs_b, q0_b, busy_b, done_b);
        end
        do_en(2);
        checks++;
        if ({qm_b, qs_b, q0_b} !== 16'h0003 || done_b !== 1'b1 || busy_b !== 1'b1) begin
            errors++;
            $display("FAIL reload_second: got %h%h%h busy=%b done=%b, want 0003 1 1", qm_b, qs_b, q0_b, busy_b, done_b);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        r = 1'b1; en = 1'b0; ld = 1'b0; go = 1'b0; stop = 1'b0;
        t_in = 4'h0; s_in = 8'h00; m_in = 4'h0;
        test_reset();
        test_reset_mid_run();
        test_borrow_chain();
        test_pause_resume();
        test_priority();
        test_clamp_zero();
        test_auto_reload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- BCD countdown timer: the down-counting counterpart of the team's up-counting m:ss.t timing counter.
- Loads a preset minutes:seconds.tenths value and decrements it once per qualified `en` tick until it reaches 0:00.0.
- On reaching zero it raises a one-cycle `done` pulse.
- Outputs use the same digit layout as the up-counter (`q0` tenths, `qs` seconds BCD, `qm` minutes), so the existing display path is reused.

Parameters:
- AUTO_RELOAD, 0, 1 = on expiry reload the last preset and keep running; 0 = stop in DONE.

Ports:
- clk  input  1  system clock, all state changes on rising edge
- r  input  1  synchronous reset, active-high
- en  input  1  one-cycle time-base tick (one tenth of a second); acted on only in RUN
- ld  input  1  load preset from t_in/s_in/m_in
- t_in  input  4  preset tenths, BCD 0-9
- s_in  input  8  preset seconds, BCD 00-59 ([7:4] tens, [3:0] units)
- m_in  input  4  preset minutes, 0-9
- go  input  1  start/resume counting
- stop  input  1  pause counting
- q0  output  4  current tenths, BCD
- qs  output  8  current seconds, BCD
- qm  output  4  current minutes
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse on expiry

Behaviour:
- Reset (r=1 at a clk edge): q0=0, qs=8'h00, qm=0, preset register=0, busy=0, done=0, state=IDLE. Reset overrides every other input.
- States: IDLE, RUN, PAUSE, DONE. busy is 1 exactly when state=RUN.
- Input priority per edge: r > ld > stop > go > en.
- ld (any state):
  - Clamp the inputs: any BCD digit >9 becomes 9; seconds tens >5 becomes 5.
  - Write the clamped value to both the count and the preset register.
  - state -> IDLE; done=0. A load therefore aborts a run in progress.
- go:
  - From IDLE or PAUSE with count nonzero: -> RUN.
  - From IDLE or PAUSE with count zero: -> DONE, done=1 for that cycle.
  - Ignored in RUN and DONE.
- stop:
  - RUN -> PAUSE; the count is held.
  - In all other states stop is ignored.
  - stop and go asserted together: stop wins.
- en in RUN: decrement the count at that edge, visible in the following cycle.
  - Tenths: q0 = q0-1. If q0=0, q0 wraps to 9 and the seconds borrow.
  - Seconds units: units-1. If units=0, units wraps to 9 and the seconds tens borrow.
  - Seconds tens: tens-1. If tens=0, qs wraps to 8'h59 and minutes borrow.
  - Minutes: qm-1.
- Expiry: when the decrement produces 0:00.0, on that same edge:
  - state -> DONE and done=1, both visible in the cycle after the edge.
  - done stays high for exactly one cycle.
  - AUTO_RELOAD=1: the count is loaded from the preset and the state stays RUN; done still pulses once.
- en outside RUN: ignored. en coincident with ld or stop: the decrement is suppressed.
- DONE: the count is held at 0:00.0. Leave DONE only via ld or r.
- Count values are always legal BCD: q0 ≤9, qs ≤8'h59, qm ≤9. Illegal codes are never produced.
- No combinational paths from inputs to outputs; all outputs are registered.

Test Plan:
- Reset mid-run:
  - Load 1:30.5, go, 5 en ticks, assert r for one cycle.
  - Next cycle: q0=0, qs=8'h00, qm=0, busy=0, done=0.
  - A subsequent en leaves the count unchanged.
- Borrow chain:
  - Load 1:00.0, go, one en.
  - Required: q0=9, qs=8'h59, qm=0, busy=1.
  - After 599 more en ticks: 0:00.0, done high exactly one cycle, busy=0.
- Pause/resume:
  - Load 0:02.0, go, 3 en ticks, giving 0:01.7.
  - stop, then 4 en ticks: count stays 0:01.7.
  - go, then 17 en ticks: done pulses, state DONE.
- Priority and simultaneous events:
  - In RUN at 0:05.0, assert ld (preset 0:03.0) and en on the same edge: count=0:03.0, state IDLE, no decrement.
  - Assert stop+go together from RUN: PAUSE.
- Clamping and zero start:
  - ld with s_in=8'h7A, t_in=4'hF, m_in=4'hC: result 9:59.9.
  - Load 0:00.0, then go: done=1 the next cycle, busy never asserted.
- AUTO_RELOAD=1:
  - Load 0:00.3, go, 3 en ticks: done pulses once, count returns to 0:00.3, busy stays 1.
  - 3 more en ticks: second done pulse.
